// File: rtl/bcd_pkg.sv
// Shared BCD types, digit limits and helpers for the BCD timer.
// Imported by the digit cell and the timer top.
package bcd_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;
    localparam bcd_t BCD_MIN = 4'd0;

    // Out-of-range nibbles (A..F) saturate to the largest decimal digit.
    function automatic bcd_t bcd_clamp(input bcd_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One combinational BCD digit cell: increment or decrement when enabled,
// with carry (up) or borrow (down) out to the next digit.
module bcd_digit
    import bcd_pkg::*;
(
    input  bcd_t d,
    input  logic en,
    input  logic up,
    output bcd_t q,
    output logic co
);

    // Next digit value and ripple out; idle when not enabled.
    always_comb begin
        q  = d;
        co = 1'b0;
        if (en) begin
            if (up) begin
                if (d >= BCD_MAX) begin
                    q  = BCD_MIN;
                    co = 1'b1;
                end else begin
                    q = d + 4'd1;
                end
            end else begin
                if (d == BCD_MIN) begin
                    q  = BCD_MAX;
                    co = 1'b1;
                end else begin
                    q = d - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_timer.sv
// N-digit BCD up/down timer with prescaler, preload, wrap or saturate
// at terminal count, and a lap/freeze display register.
module bcd_timer
    import bcd_pkg::*;
#(
    parameter int NDIG = 3,
    parameter int DVSR = 5_000_000,
    parameter int WRAP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic              clr,
    input  logic              up,
    input  logic              load,
    input  logic [4*NDIG-1:0] load_val,
    input  logic              lap,
    output logic [4*NDIG-1:0] digits,
    output logic [4*NDIG-1:0] disp,
    output logic              tick,
    output logic              tc,
    output logic              done,
    output logic              frozen
);

    localparam int DW = 4 * NDIG;
    localparam int PW = $clog2(DVSR);
    localparam logic [PW-1:0] PMAX = PW'(DVSR - 1);
    localparam bit SAT = (WRAP == 0);

    logic [PW-1:0] psc_q, psc_d;
    logic [DW-1:0] dig_q, dig_d;
    logic [DW-1:0] frz_q, frz_d;
    logic          done_q, done_d;
    logic          frz_on_q, frz_on_d;

    logic [DW-1:0] nxt;
    logic [DW-1:0] ld_clamped;
    logic [NDIG:0] cy;
    logic          at_tc;

    // Count step strobe; clr, load and reset all pre-empt a step.
    always_comb begin
        tick = !rst && !clr && !load && go && !done_q && (psc_q == PMAX);
    end

    // Ripple chain: the carry out of the top digit only fires when every
    // digit sits at the terminal value for the current direction.
    assign cy[0] = tick;

    for (genvar g = 0; g < NDIG; g++) begin : g_dig
        bcd_digit u_dig (
            .d  (dig_q[4*g +: 4]),
            .en (cy[g]),
            .up (up),
            .q  (nxt[4*g +: 4]),
            .co (cy[g+1])
        );
    end

    assign tc = cy[NDIG];

    // Terminal-value detect, used to release a saturated count.
    always_comb begin
        at_tc = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (dig_q[4*i +: 4] != (up ? BCD_MAX : BCD_MIN)) begin
                at_tc = 1'b0;
            end
        end
    end

    // Per-digit clamp of the preload value.
    always_comb begin
        ld_clamped = '0;
        for (int i = 0; i < NDIG; i++) begin
            ld_clamped[4*i +: 4] = bcd_clamp(load_val[4*i +: 4]);
        end
    end

    // Next-state: clr beats load beats count step; lap is independent
    // of load but ignored under clr.
    always_comb begin
        psc_d    = psc_q;
        dig_d    = dig_q;
        done_d   = done_q;
        frz_d    = frz_q;
        frz_on_d = frz_on_q;
        if (clr) begin
            psc_d    = '0;
            dig_d    = '0;
            done_d   = 1'b0;
            frz_on_d = 1'b0;
        end else begin
            if (lap) begin
                if (frz_on_q) begin
                    frz_on_d = 1'b0;
                end else begin
                    frz_on_d = 1'b1;
                    frz_d    = dig_q;
                end
            end
            if (load) begin
                dig_d  = ld_clamped;
                psc_d  = '0;
                done_d = 1'b0;
            end else begin
                if (go && !done_q) begin
                    psc_d = (psc_q == PMAX) ? '0 : psc_q + 1'b1;
                end
                if (tc && SAT) begin
                    done_d = 1'b1;
                end else if (tick) begin
                    dig_d = nxt;
                end else if (done_q && !at_tc) begin
                    done_d = 1'b0;
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            psc_q    <= '0;
            dig_q    <= '0;
            frz_q    <= '0;
            done_q   <= 1'b0;
            frz_on_q <= 1'b0;
        end else begin
            psc_q    <= psc_d;
            dig_q    <= dig_d;
            frz_q    <= frz_d;
            done_q   <= done_d;
            frz_on_q <= frz_on_d;
        end
    end

    assign digits = dig_q;
    assign disp   = frz_on_q ? frz_q : dig_q;
    assign done   = done_q;
    assign frozen = frz_on_q;

endmodule
